// File: rtl/memoria_dados_if.sv
// Load/store bus between the datapath (master) and the data memory (slave).
// Strobes, address and store data go in; load data and completion status come back.
interface memoria_dados_if;
  logic        MemoriaLida;
  logic        MemoriaEscrita;
  logic [31:0] Endereco;
  logic [31:0] DadosEscrita;
  logic [31:0] DadosLidos;
  logic        Pronto;
  logic        Ocupado;
  logic        ErroAcesso;

  modport master (
    output MemoriaLida, MemoriaEscrita, Endereco, DadosEscrita,
    input  DadosLidos, Pronto, Ocupado, ErroAcesso
  );

  modport slave (
    input  MemoriaLida, MemoriaEscrita, Endereco, DadosEscrita,
    output DadosLidos, Pronto, Ocupado, ErroAcesso
  );
endinterface

// File: rtl/memoria_dados.sv
// Word-organised data memory; fixed LATENCY cycles from acceptance to Pronto.
// Requests are accepted only in IDLE; while Ocupado the bus inputs are ignored.
module memoria_dados #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input logic            clock,
  input logic            reset,
  memoria_dados_if.slave bus
);
  localparam logic [1:0]  IDLE    = 2'd0;
  localparam logic [1:0]  ESPERA  = 2'd1;
  localparam logic [1:0]  FIM     = 2'd2;
  localparam int          IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);
  localparam logic [3:0]  CNT_INI = 4'(LATENCY - 1);

  logic [1:0]    estado;
  logic [3:0]    contador;
  logic [IW-1:0] indice;
  logic [31:0]   dado;
  logic          escrita;
  logic          erro;
  logic [31:0]   lidos;
  logic          erro_acesso;
  logic [31:0]   mem [DEPTH];
  logic          pedido;
  logic          erro_novo;

  // The whole error decision is made at acceptance so later stages only act on latched state.
  always_comb begin
    pedido    = bus.MemoriaLida | bus.MemoriaEscrita;
    erro_novo = (bus.Endereco[1:0] != 2'b00)
             || ({2'b00, bus.Endereco[31:2]} >= DEPTH_W)
             || (bus.MemoriaLida && bus.MemoriaEscrita);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado      <= IDLE;
      contador    <= 4'd0;
      indice      <= '0;
      dado        <= 32'd0;
      escrita     <= 1'b0;
      erro        <= 1'b0;
      lidos       <= 32'd0;
      erro_acesso <= 1'b0;
    end else begin
      case (estado)
        IDLE: begin
          if (pedido) begin
            estado   <= ESPERA;
            contador <= CNT_INI;
            indice   <= bus.Endereco[IW+1:2];
            dado     <= bus.DadosEscrita;
            escrita  <= bus.MemoriaEscrita;
            erro     <= erro_novo;
          end
        end
        ESPERA: begin
          if (contador == 4'd0) estado <= FIM;
          else                  contador <= contador - 4'd1;
        end
        FIM: begin
          estado      <= IDLE;
          erro_acesso <= erro;
          if (!erro && !escrita) lidos <= mem[indice];
        end
        default: estado <= IDLE;
      endcase
    end
  end

  // Reset clears every word, which also discards any write still in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'd0;
    end else if (estado == FIM && escrita && !erro) begin
      mem[indice] <= dado;
    end
  end

  assign bus.DadosLidos = lidos;
  assign bus.ErroAcesso = erro_acesso;
  assign bus.Pronto     = (estado == FIM);
  assign bus.Ocupado    = (estado == ESPERA) || (estado == FIM);
endmodule

// File: doc/memoria_dados.md
Name: memoria_dados

Overview:
- Word-organised data memory. It is the responder to the load/store strobes (MemoriaLida, MemoriaEscrita) that the control unit raises for I-type loads and S-type stores.
- Sits after the ALU: the ALU result is the byte address, and register-file Data2 supplies the store data.
- Latency is multi-cycle and fixed by parameter. The datapath stalls on Ocupado and resumes on Pronto.
- Misaligned, out-of-range and conflicting requests are reported through a status flag.

Parameters:
- DEPTH, 64, number of 32-bit words; valid word index is 0..DEPTH-1.
- LATENCY, 2, cycles from request acceptance to Pronto; legal range 1..15.

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  reset; one clock; reset is asynchronous and active-low.
- MemoriaLida  input  1  read request.
- MemoriaEscrita  input  1  write request.
- Endereco  input  32  byte address.
- DadosEscrita  input  32  store data.
- DadosLidos  output  32  load data; held between reads.
- Pronto  output  1  one-cycle completion pulse.
- Ocupado  output  1  high while a request is in progress.
- ErroAcesso  output  1  qualifies Pronto: the completed request was rejected.

Behaviour:
- Reset (reset=0, asynchronous):
  - State returns to IDLE.
  - Counter is 0; latched request is cleared.
  - DadosLidos=0, Pronto=0, Ocupado=0, ErroAcesso=0.
  - All DEPTH words are cleared to 0.
  - An in-flight write is aborted: the memory is not modified.
- FSM states: IDLE, ESPERA, FIM.
- IDLE:
  - A request is MemoriaLida|MemoriaEscrita sampled high at a rising edge.
  - On a request: latch Endereco, DadosEscrita, the request type and the error condition; load counter=LATENCY-1; go to ESPERA.
- ESPERA:
  - Ocupado=1.
  - If counter=0, go to FIM; otherwise decrement counter.
  - Inputs are ignored; only latched values are used.
- FIM:
  - Ocupado=1 and Pronto=1 for exactly this one cycle.
  - On the edge leaving FIM (next state IDLE):
    - Valid write: memory word is written with the latched data.
    - Valid read: DadosLidos is loaded with the word.
    - Error: ErroAcesso is set and the memory is untouched.
  - ErroAcesso and the new DadosLidos are visible from that edge.
  - ErroAcesso holds until the next completion.
  - Requests present during FIM are not accepted.
- Latency:
  - Acceptance at edge t0 gives Pronto high in cycle t0+LATENCY to t0+LATENCY+1.
  - Read data is available at edge t0+LATENCY+1.
  - Minimum request-to-request spacing is LATENCY+2 edges.
  - The initiator deasserts its strobe on Pronto; a strobe still high in IDLE is a new request.
- Word index: Endereco[31:2].
- Error conditions (evaluated at acceptance):
  - Endereco[1:0]!=0 (misaligned).
  - Endereco[31:2]>=DEPTH (out of range).
  - MemoriaLida and MemoriaEscrita both high.
  - An error request completes with the same latency. DadosLidos is unchanged and there is no write.
- Reading a word in the same request as writing it cannot occur; a read after a write returns the new data.
- Ocupado is derived from state (ESPERA or FIM); Pronto is derived from state (FIM).

Test Plan:
- Reset, then read address 0x10 with LATENCY=2 -> Pronto 2 cycles after acceptance, DadosLidos=0x00000000, ErroAcesso=0.
- Write 0xDEADBEEF to 0x08, then read 0x08 -> second completion DadosLidos=0xDEADBEEF; words 0x04 and 0x0C still read 0.
- Read 0x06 (misaligned) and read 0x100 (index 64, DEPTH=64) -> each gives Pronto with ErroAcesso=1; DadosLidos keeps its previous value; memory unchanged.
- MemoriaLida=MemoriaEscrita=1 at 0x04 with data 0x55 -> ErroAcesso=1; a subsequent read of 0x04 returns 0.
- Write 0x1234 to 0x0C, assert reset while in ESPERA -> outputs 0 immediately; a read of 0x0C after reset returns 0.
- Toggle MemoriaLida during ESPERA/FIM and sweep LATENCY in 1,4 -> exactly one Pronto per accepted request; Ocupado high for exactly LATENCY+1 cycles.
